ccu_mult_seq: RTL
=================

Name: ccu_mult_seq

Overview:
- Multiplication sequencer for the EDSAC arithmetic unit.
- On a multiply order it aligns to the next even minor cycle and runs one partial-product step per even/odd minor-cycle pair.
- Each step drives the add/subtract enable, the `dy` partial-product reset pulse and the multiplier shift pulse.
- It consumes the odd/even timing pulses from the CCU timing generator and controls the accumulator/multiplier datapath.

Parameters:
- SHORT_STEPS, 17, number of steps for a short (17-digit) multiply.
- LONG_STEPS, 35, number of steps for a long (35-digit) multiply.
- CNT_W, 6, width of the step counter; must satisfy 2^CNT_W > LONG_STEPS.

Ports:
- clk  input  1  system clock; one clock per digit time.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-clock multiply-order request from order decode.
- long_mode  input  1  sampled with start; 1 selects LONG_STEPS, 0 selects SHORT_STEPS.
- ev_d0  input  1  d0 pulse of an even minor cycle.
- odd_d35  input  1  d35 pulse of an odd minor cycle.
- mult_digit  input  1  current least-significant multiplier digit, valid at ev_d0.
- busy  output  1  high from the start acceptance edge until done is asserted.
- pp_add  output  1  add multiplicand into the accumulator during the current pair.
- pp_sub  output  1  subtract multiplicand during the current pair (sign step only).
- dy  output  1  one-clock partial-product reset pulse, end of each pair.
- mshift  output  1  one-clock multiplier shift pulse, coincident with dy.
- done  output  1  one-clock completion pulse.
- step_cnt  output  CNT_W  index of the current step, 0-based.

Behaviour:
- Reset, asynchronous and mid-operation alike:
  - state = IDLE;
  - busy, pp_add, pp_sub, dy, mshift and done = 0;
  - step_cnt = 0;
  - any multiply in progress is abandoned, with no done pulse.
- All outputs are registered.
- States are IDLE, SYNC, STEP, GAP, FIN.
- IDLE:
  - start=1 → SYNC; latch N = long_mode ? LONG_STEPS : SHORT_STEPS; busy=1; step_cnt=0.
  - start while not IDLE is ignored; no queueing.
- SYNC: wait for ev_d0. Even if ev_d0 coincides with the start edge, the request waits for the next ev_d0, because start is only seen in IDLE.
- SYNC or GAP with ev_d0=1 → STEP, with the digit sampled on that edge:
  - if mult_digit=1 and step_cnt<N-1: pp_add=1;
  - if mult_digit=1 and step_cnt==N-1 (sign digit, two's complement): pp_sub=1;
  - mult_digit=0: neither is asserted.
  - pp_add and pp_sub are never both 1.
- STEP with odd_d35=1 → GAP (or FIN on the last step) on that edge:
  - pp_add and pp_sub cleared;
  - dy=1 and mshift=1 for exactly one clock;
  - step_cnt increments, except on the last step, where it holds at N-1.
- Last step (step_cnt==N-1 at odd_d35) → FIN.
- FIN: done=1 and busy=0 on the same edge. The next edge → IDLE with done=0 and step_cnt=0.
- ev_d0 seen in STEP (no odd_d35 yet) is ignored; the pair is always completed.
- odd_d35 seen in SYNC or GAP is ignored.
- Both pulses high together cannot occur legally. If it happens, the state-appropriate pulse wins and the other is ignored.
- Latency:
  - the first pp_add/pp_sub appears 1 clock after the first ev_d0 following start;
  - a full multiply takes N even/odd pairs plus 1 clock.

Decomposition:
- Shared package ccu_pkg holds:
  - the state enumeration;
  - SHORT_STEPS and LONG_STEPS;
  - the minor-cycle length constant (36 digit times).
- One natural sub-module: ccu_step_counter (load/increment/terminal-count compare, CNT_W wide).
- The FSM and output registers stay in ccu_mult_seq.

Test Plan:
- Short multiply:
  - stimulus: start, long_mode=0, mult_digit pattern 1,0,…,0 (17 steps), bench timing generator with 72-clock pair period;
  - required: pp_add high only in pair 0; 17 dy pulses; done 1 clock after the 17th odd_d35; busy low with done.
- Long multiply:
  - stimulus: start, long_mode=1, mult_digit all 1;
  - required: pp_add in steps 0–33; pp_sub (not pp_add) in step 34; 35 dy/mshift pulses; step_cnt reaches 34.
- Alignment:
  - stimulus: start asserted during an odd minor cycle;
  - required: no pp_add/pp_sub/dy until after the next ev_d0; the first pp_add rises 1 clock after that ev_d0.
- Start while busy:
  - stimulus: second start in step 5;
  - required: ignored; exactly one done pulse; step count unaffected.
- Reset mid-operation:
  - stimulus: rst asserted in step 10 between clock edges;
  - required: all outputs 0 immediately; step_cnt=0; no done; a subsequent start gives a normal full sequence.
- Zero multiplier:
  - stimulus: mult_digit all 0, short mode;
  - required: pp_add=pp_sub=0 throughout; still 17 dy/mshift pulses, then done.

Source files
------------

// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU multiplication sequencer: FSM states,
// step counts for short/long multiplies and the minor-cycle length.
package ccu_pkg;

    localparam int SHORT_STEPS = 17;
    localparam int LONG_STEPS  = 35;
    localparam int MINOR_CYCLE = 36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STEP,
        ST_GAP,
        ST_FIN
    } mult_state_t;

endpackage

// File: rtl/ccu_step_counter.sv
// Step counter for the multiplication sequencer: loads a terminal value,
// counts steps from zero and flags the final (sign) step.
module ccu_step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] last_val_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d  = '0;
            last_d = last_val_i;
        end else if (inc_i && (cnt_q != last_q)) begin
            // Saturates at the terminal value so the last step index holds.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == last_q);

endmodule

// File: rtl/ccu_mult_seq.sv
// EDSAC multiplication sequencer: aligns to even minor cycles and runs one
// partial-product step per even/odd pair, driving add/sub, dy and shift.
module ccu_mult_seq #(
    parameter int SHORT_STEPS = ccu_pkg::SHORT_STEPS,
    parameter int LONG_STEPS  = ccu_pkg::LONG_STEPS,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             long_mode,
    input  logic             ev_d0,
    input  logic             odd_d35,
    input  logic             mult_digit,
    output logic             busy,
    output logic             pp_add,
    output logic             pp_sub,
    output logic             dy,
    output logic             mshift,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
);

    import ccu_pkg::*;

    mult_state_t state_q, state_d;
    logic busy_q, busy_d;
    logic pp_add_q, pp_add_d;
    logic pp_sub_q, pp_sub_d;
    logic dy_q, dy_d;
    logic mshift_q, mshift_d;
    logic done_q, done_d;

    logic             cnt_load, cnt_inc, cnt_clr, cnt_last;
    logic [CNT_W-1:0] cnt_last_val;
    logic [CNT_W-1:0] cnt_val;

    assign cnt_last_val = long_mode ? CNT_W'(LONG_STEPS - 1) : CNT_W'(SHORT_STEPS - 1);

    ccu_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .last_val_i (cnt_last_val),
        .inc_i      (cnt_inc),
        .clr_i      (cnt_clr),
        .cnt_o      (cnt_val),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        pp_add_d = pp_add_q;
        pp_sub_d = pp_sub_q;
        dy_d     = 1'b0;
        mshift_d = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SYNC;
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            ST_SYNC, ST_GAP: begin
                // The sign digit carries negative weight, so it subtracts.
                if (ev_d0) begin
                    state_d  = ST_STEP;
                    pp_add_d = mult_digit & ~cnt_last;
                    pp_sub_d = mult_digit & cnt_last;
                end
            end
            ST_STEP: begin
                if (odd_d35) begin
                    pp_add_d = 1'b0;
                    pp_sub_d = 1'b0;
                    dy_d     = 1'b1;
                    mshift_d = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            pp_add_q <= 1'b0;
            pp_sub_q <= 1'b0;
            dy_q     <= 1'b0;
            mshift_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            pp_add_q <= pp_add_d;
            pp_sub_q <= pp_sub_d;
            dy_q     <= dy_d;
            mshift_q <= mshift_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign pp_add   = pp_add_q;
    assign pp_sub   = pp_sub_q;
    assign dy       = dy_q;
    assign mshift   = mshift_q;
    assign done     = done_q;
    assign step_cnt = cnt_val;

endmodule
